div_seq: RTL and testbench

//  Iterative 32/32 divider and its sequencing FSM. Serves DIV/DIVU decoded in ID (hilo_inst 4'b0111/4'b1000).

---
 rtl/div_seq_pkg.sv | 31 +++
 rtl/div_seq_step.sv | 46 ++++
 rtl/div_seq.sv | 160 ++++++++++++++++
 tb/tb_div_seq.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : div_seq_pkg
// Purpose : Shared definitions for the iterative divider. This package holds
//           the FSM state codes, the ready and start level names, and the
//           default widths used by div_seq and div_seq_step.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package div_seq_pkg;

  // Default operand width. The iteration counter must be able to hold WIDTH.
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  // FSM state codes
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Level names for the ready output and the start input
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage : div_seq_pkg
`default_nettype wire

// File: rtl/div_seq_step.sv
`default_nettype none
// ============================================================================
// Module  : div_seq_step
// Purpose : One combinational radix-2 restoring shift-subtract stage.
//           The stage shifts the {remainder, dividend/quotient} register left
//           by one bit. It then subtracts the divisor from the upper field.
//           If the result is non-negative, the stage keeps the difference and
//           sets the new quotient LSB to 1. Otherwise it keeps the shifted
//           value and sets the quotient LSB to 0.
// Ports   : rem_in   [2*WIDTH:0]  current shift register
//           divisor  [WIDTH-1:0]  divisor magnitude
//           rem_out  [2*WIDTH:0]  shift register after this step
// Revision: 1.0  initial release
// ============================================================================
module div_seq_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  rem_in,
  input  logic [WIDTH-1:0]  divisor,
  output logic [2*WIDTH:0]  rem_out
);

  logic [WIDTH:0]   w_upper;
  logic [WIDTH+1:0] w_diff;
  logic             w_q_bit;

  // This is the upper field after the left shift. The partial remainder is
  // always below the divisor, so the top register bit is always clear. It is
  // OR-ed into the top bit, which leaves the result unchanged and uses every
  // register bit.
  assign w_upper = {rem_in[2*WIDTH] | rem_in[2*WIDTH-1], rem_in[2*WIDTH-2:WIDTH-1]};

  // The subtraction has one guard bit. Its MSB is set when the trial goes
  // negative.
  assign w_diff  = {1'b0, w_upper} - {2'b00, divisor};
  assign w_q_bit = ~w_diff[WIDTH+1];

  always_comb begin
    rem_out = {w_upper, rem_in[WIDTH-2:0], 1'b0};
    if (w_q_bit) begin
      rem_out = {w_diff[WIDTH:0], rem_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule : div_seq_step
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module  : div_seq
// Purpose : Iterative 32/32 divider and its sequencing FSM for DIV/DIVU.
//           EX raises start with the rs/rt operands. This block stalls the
//           pipeline until the {remainder, quotient} pair is ready.
//           The algorithm is radix-2 restoring and produces one quotient bit
//           per cycle.
// Ports   : clk         system clock
//           rst         synchronous reset, active low
//           start       a DIV/DIVU is in flight; held high while stalled
//           signed_div  1 = DIV (two's complement), 0 = DIVU
//           opdata1     dividend, sampled on acceptance only
//           opdata2     divisor, sampled on acceptance only
//           annul       flush; abandon the current operation
//           result      {hi = remainder, lo = quotient}, valid while ready
//           ready       result valid (END state)
//           stallreq    hold request to the pipeline controller
// Revision: 1.0  initial release
// ============================================================================
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stallreq
);

  localparam logic [CNT_W-1:0] c_last_step = CNT_W'(WIDTH - 1);

  div_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH:0]   r_dividend;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_q_neg;
  logic               r_r_neg;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;

  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic [2*WIDTH:0]   w_step;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // Returns the magnitude of v when the operation is signed, otherwise v
  // unchanged. The value -2^(WIDTH-1) maps to itself. Read as unsigned, it is
  // the correct magnitude.
  function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v,
                                             input logic             is_signed);
    if (is_signed && v[WIDTH-1]) begin
      return {WIDTH{1'b0}} - v;
    end
    return v;
  endfunction

  assign w_abs1 = f_abs(opdata1, signed_div);
  assign w_abs2 = f_abs(opdata2, signed_div);

  div_seq_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (r_dividend),
    .divisor (r_divisor),
    .rem_out (w_step)
  );

  // Sign fix applied on the final step. The quotient is negative when the
  // operand signs differ. The remainder takes the sign of the dividend.
  assign w_quot     = w_step[WIDTH-1:0];
  assign w_rem      = w_step[2*WIDTH-1:WIDTH];
  assign w_quot_fix = r_q_neg ? ({WIDTH{1'b0}} - w_quot) : w_quot;
  assign w_rem_fix  = r_r_neg ? ({WIDTH{1'b0}} - w_rem)  : w_rem;

  // Combinational, so the pipeline holds in the same cycle as the request.
  assign stallreq = start & ~annul & (r_state != DivEnd);
  assign result   = r_result;
  assign ready    = r_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= DivFree;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_result   <= '0;
      r_ready    <= DivResultNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          r_ready <= DivResultNotReady;
          if (start == DivStart && !annul) begin
            r_divisor  <= w_abs2;
            r_q_neg    <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            r_r_neg    <= signed_div & opdata1[WIDTH-1];
            r_dividend <= {{(WIDTH+1){1'b0}}, w_abs1};
            r_cnt      <= '0;
            r_state    <= (opdata2 == '0) ? DivByZero : DivOn;
          end
        end

        DivByZero: begin
          if (annul) begin
            r_ready <= DivResultNotReady;
            r_state <= DivFree;
          end else begin
            r_result <= '0;
            r_ready  <= DivResultReady;
            r_state  <= DivEnd;
          end
        end

        DivOn: begin
          if (annul) begin
            r_ready <= DivResultNotReady;
            r_state <= DivFree;
          end else begin
            r_dividend <= w_step;
            r_cnt      <= r_cnt + CNT_W'(1);
            if (r_cnt == c_last_step) begin
              r_result <= {w_rem_fix, w_quot_fix};
              r_ready  <= DivResultReady;
              r_state  <= DivEnd;
            end
          end
        end

        DivEnd: begin
          // Hold the result while EX keeps start high. Release when start
          // drops or on a flush.
          if (annul || start == DivStop) begin
            r_ready <= DivResultNotReady;
            r_state <= DivFree;
          end
        end

        default: begin
          r_ready <= DivResultNotReady;
          r_state <= DivFree;
        end
      endcase
    end
  end

endmodule : div_seq
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_div_seq
// Purpose : Directed self-checking bench for div_seq. It checks the result,
//           the latency, the stall cycles, the handshake, annul and reset.
// Ports   : none
// Revision: 1.0  initial release
// ============================================================================
module tb_div_seq;

  logic        clk        = 1'b0;
  logic        rst        = 1'b0;
  logic        start      = 1'b0;
  logic        signed_div = 1'b0;
  logic        annul      = 1'b0;
  logic [31:0] opdata1    = '0;
  logic [31:0] opdata2    = '0;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int checks   = 0;
  int failures = 0;

  div_seq #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .stallreq   (stallreq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one divide with start held until ready. Then verify the hold
  // behaviour in END and the release after start drops.
  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat,
                         input logic [63:0] exp_res, input bit scramble);
    int cycles;
    int stalls;
    @(negedge clk);
    start = 1'b1; signed_div = s; opdata1 = a; opdata2 = b;
    #1;
    check({tag, " stall_accept"}, {63'b0, stallreq}, 64'd1);
    stalls = 1;
    cycles = 0;
    while (cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (ready) break;
      stalls += int'(stallreq);
      if (scramble) begin
        opdata1 = $urandom;
        opdata2 = $urandom;
      end
    end
    check({tag, " latency"},   64'(cycles), 64'(exp_lat));
    check({tag, " stalls"},    64'(stalls), 64'(exp_lat));
    check({tag, " result"},    result, exp_res);
    check({tag, " stall_end"}, {63'b0, stallreq}, 64'd0);
    @(negedge clk);
    check({tag, " hold_ready"},  {63'b0, ready}, 64'd1);
    check({tag, " hold_result"}, result, exp_res);
    start = 1'b0;
    @(negedge clk);
    check({tag, " release"}, {63'b0, ready}, 64'd0);
  endtask

  initial begin
    int ready_seen;

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst ready",    {63'b0, ready},    64'd0);
    check("rst result",   result,            64'd0);
    check("rst stallreq", {63'b0, stallreq}, 64'd0);
    rst = 1'b1;

    // Directed divides: {hi = remainder, lo = quotient}
    run_div("divu_100_7",  1'b0, 32'd100,        32'd7,          33, {32'd2,          32'd14},          1'b0);
    run_div("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          33, {32'hFFFF_FFFF,  32'hFFFF_FFFD},   1'b0);
    run_div("div_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  33, {32'd1,          32'hFFFF_FFFD},   1'b0);
    run_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  33, {32'hFFFF_FFFE,  32'd14},          1'b0);
    run_div("div_by_zero", 1'b0, 32'h0000_1234,  32'd0,           2, 64'd0,                            1'b0);
    run_div("div_minint",  1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  33, {32'd0,          32'h8000_0000},   1'b0);
    run_div("divu_big",    1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  33, {32'h8000_0000,  32'd0},           1'b0);
    run_div("divu_by_one", 1'b0, 32'hFFFF_FFFF,  32'd1,          33, {32'd0,          32'hFFFF_FFFF},   1'b0);
    run_div("divu_small",  1'b0, 32'd5,          32'd10,         33, {32'd5,          32'd0},           1'b0);
    run_div("divu_dead",   1'b0, 32'hDEAD_BEEF,  32'h10,         33, {32'hF,          32'h0DEA_DBEE},   1'b0);

    // Annul during ON, around step 10
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    #1;
    check("annul stallreq", {63'b0, stallreq}, 64'd0);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    check("annul ready",  {63'b0, ready}, 64'd0);
    check("annul result", result, {32'hF, 32'h0DEA_DBEE});
    run_div("after_annul", 1'b0, 32'd1000, 32'd3, 33, {32'd1, 32'd333}, 1'b0);

    // Annul takes priority over start in IDLE
    @(negedge clk);
    start = 1'b1; annul = 1'b1; opdata1 = 32'd50; opdata2 = 32'd5;
    #1;
    check("idle_annul stallreq", {63'b0, stallreq}, 64'd0);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    ready_seen = 0;
    repeat (40) begin
      @(negedge clk);
      ready_seen += int'(ready);
    end
    check("idle_annul no_ready", 64'(ready_seen), 64'd0);

    // Reset in the middle of ON
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    repeat (6) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("midrst ready",    {63'b0, ready},    64'd0);
    check("midrst stallreq", {63'b0, stallreq}, 64'd0);
    check("midrst result",   result,            64'd0);
    rst = 1'b1;

    // Operands scrambled after acceptance must not affect the result
    run_div("div_scramble", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_div_seq
`default_nettype wire
